// File: rtl/rv_exec_sequencer_if.sv
// Handshake bundle between the exec sequencer and its instruction memory,
// register file read ports and ALU.
interface rv_exec_sequencer_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_rd_addr;
  logic            mem_rd_addr_valid;
  logic [31:0]     mem_rd_data;
  logic            mem_rd_ack;

  logic [4:0]      reg_rd_addr_a;
  logic [4:0]      reg_rd_addr_b;
  logic            reg_rd_a_valid;
  logic            reg_rd_b_valid;
  logic [XLEN-1:0] reg_rd_data_a;
  logic [XLEN-1:0] reg_rd_data_b;
  logic            reg_rd_a_ack;
  logic            reg_rd_b_ack;

  logic [3:0]      alu_op_code;
  logic [XLEN-1:0] alu_input_A;
  logic [XLEN-1:0] alu_input_B;
  logic [4:0]      alu_reg_addr;
  logic            alu_inputs_valid;
  logic            alu_ready;
  logic [XLEN-1:0] alu_pc_branch_data;
  logic            alu_pc_branch_data_valid;
  logic            done;

  modport master (
    output mem_rd_addr, mem_rd_addr_valid,
    input  mem_rd_data, mem_rd_ack,
    output reg_rd_addr_a, reg_rd_addr_b, reg_rd_a_valid, reg_rd_b_valid,
    input  reg_rd_data_a, reg_rd_data_b, reg_rd_a_ack, reg_rd_b_ack,
    output alu_op_code, alu_input_A, alu_input_B, alu_reg_addr, alu_inputs_valid,
    input  alu_ready, alu_pc_branch_data, alu_pc_branch_data_valid, done
  );

  modport slave (
    input  mem_rd_addr, mem_rd_addr_valid,
    output mem_rd_data, mem_rd_ack,
    input  reg_rd_addr_a, reg_rd_addr_b, reg_rd_a_valid, reg_rd_b_valid,
    output reg_rd_data_a, reg_rd_data_b, reg_rd_a_ack, reg_rd_b_ack,
    input  alu_op_code, alu_input_A, alu_input_B, alu_reg_addr, alu_inputs_valid,
    output alu_ready, alu_pc_branch_data, alu_pc_branch_data_valid, done
  );
endinterface

// File: rtl/rv_exec_sequencer.sv
// Multi-cycle fetch/decode/dispatch sequencer for RV32 R-type and I-type ALU ops.
// All bus outputs are registered; each request is raised on entry to its wait state.
module rv_exec_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  rv_exec_sequencer_if.master bus,
  output logic [XLEN-1:0]     pc,
  output logic                illegal_instr,
  output logic [CNT_W-1:0]    instr_retired
);
  typedef enum logic [2:0] {
    S_FETCH, S_FETCH_WAIT, S_DECODE, S_REG_WAIT, S_DISPATCH, S_EXEC_WAIT, S_HALT
  } state_t;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR  = 4'd3,
                         OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7;

  state_t            state, state_nxt;
  logic [31:0]       instr_r;
  logic [XLEN-1:0]   mem_addr_r;
  logic              mem_valid_r;
  logic [4:0]        addr_a_r, addr_b_r;
  logic              a_valid_r, b_valid_r;
  logic [3:0]        op_r;
  logic [XLEN-1:0]   a_r, b_r;
  logic [4:0]        rd_r;
  logic              alu_valid_r;

  logic [6:0]        opcode, funct7;
  logic [2:0]        funct3;
  logic signed [11:0] imm_i;
  logic [XLEN-1:0]   shamt;
  logic              dec_legal, dec_need_b;
  logic [3:0]        dec_op;
  logic [XLEN-1:0]   dec_imm;
  logic              a_clear, b_clear;

  assign opcode = instr_r[6:0];
  assign funct3 = instr_r[14:12];
  assign funct7 = instr_r[31:25];
  assign imm_i  = instr_r[31:20];
  assign shamt  = {{(XLEN-5){1'b0}}, instr_r[24:20]};

  always_comb begin
    dec_legal  = 1'b0;
    dec_need_b = 1'b0;
    dec_op     = OP_ADD;
    dec_imm    = XLEN'(imm_i);
    case (opcode)
      OPC_R: begin
        dec_need_b = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          {7'b0100000, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_SUB; end
          {7'b0000000, 3'b100}: begin dec_legal = 1'b1; dec_op = OP_XOR; end
          {7'b0000000, 3'b110}: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          {7'b0000000, 3'b111}: begin dec_legal = 1'b1; dec_op = OP_AND; end
          {7'b0000000, 3'b001}: begin dec_legal = 1'b1; dec_op = OP_SLL; end
          {7'b0000000, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRL; end
          {7'b0100000, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRA; end
          default: ;
        endcase
      end
      OPC_I: begin
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_op = OP_AND; end
          // Shift immediates carry a funct7 field that must be exact.
          3'b001: begin
            dec_imm   = shamt;
            dec_op    = OP_SLL;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_imm   = shamt;
            dec_op    = funct7[5] ? OP_SRA : OP_SRL;
            dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // A port is satisfied once it was never requested or its ack arrives now.
  assign a_clear = !a_valid_r || bus.reg_rd_a_ack;
  assign b_clear = !b_valid_r || bus.reg_rd_b_ack;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: if (bus.mem_rd_ack) state_nxt = S_DECODE;
      S_DECODE:     state_nxt = dec_legal ? S_REG_WAIT : S_HALT;
      S_REG_WAIT:   if (a_clear && b_clear) state_nxt = S_DISPATCH;
      S_DISPATCH:   if (bus.alu_ready) state_nxt = S_EXEC_WAIT;
      S_EXEC_WAIT:  if (bus.done) state_nxt = S_FETCH;
      S_HALT:       state_nxt = S_HALT;
      default:      state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= RESET_PC;
      illegal_instr <= 1'b0;
      instr_retired <= '0;
      instr_r       <= '0;
      mem_addr_r    <= '0;
      mem_valid_r   <= 1'b0;
      addr_a_r      <= '0;
      addr_b_r      <= '0;
      a_valid_r     <= 1'b0;
      b_valid_r     <= 1'b0;
      op_r          <= '0;
      a_r           <= '0;
      b_r           <= '0;
      rd_r          <= '0;
      alu_valid_r   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          mem_addr_r  <= pc;
          mem_valid_r <= 1'b1;
        end
        S_FETCH_WAIT: if (bus.mem_rd_ack) begin
          instr_r     <= bus.mem_rd_data;
          mem_valid_r <= 1'b0;
        end
        S_DECODE: begin
          if (dec_legal) begin
            a_valid_r <= 1'b1;
            b_valid_r <= dec_need_b;
            addr_a_r  <= instr_r[19:15];
            addr_b_r  <= dec_need_b ? instr_r[24:20] : 5'd0;
            op_r      <= dec_op;
            rd_r      <= instr_r[11:7];
            if (!dec_need_b) b_r <= dec_imm;
          end else begin
            illegal_instr <= 1'b1;
          end
        end
        S_REG_WAIT: begin
          if (a_valid_r && bus.reg_rd_a_ack) begin
            a_r       <= bus.reg_rd_data_a;
            a_valid_r <= 1'b0;
          end
          if (b_valid_r && bus.reg_rd_b_ack) begin
            b_r       <= bus.reg_rd_data_b;
            b_valid_r <= 1'b0;
          end
          if (a_clear && b_clear) alu_valid_r <= 1'b1;
        end
        S_DISPATCH: if (bus.alu_ready) alu_valid_r <= 1'b0;
        S_EXEC_WAIT: if (bus.done) begin
          pc            <= bus.alu_pc_branch_data_valid ? bus.alu_pc_branch_data
                                                        : pc + XLEN'(4);
          instr_retired <= instr_retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_addr       = mem_addr_r;
  assign bus.mem_rd_addr_valid = mem_valid_r;
  assign bus.reg_rd_addr_a     = addr_a_r;
  assign bus.reg_rd_addr_b     = addr_b_r;
  assign bus.reg_rd_a_valid    = a_valid_r;
  assign bus.reg_rd_b_valid    = b_valid_r;
  assign bus.alu_op_code       = op_r;
  assign bus.alu_input_A       = a_r;
  assign bus.alu_input_B       = b_r;
  assign bus.alu_reg_addr      = rd_r;
  assign bus.alu_inputs_valid  = alu_valid_r;
endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Directed bench for rv_exec_sequencer: stimulus plays memory/regfile/ALU and
// queues expected fetches and dispatches; a monitor pops and compares them.
module tb_rv_exec_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic        illegal_instr;
  logic [31:0] instr_retired;

  rv_exec_sequencer_if #(.XLEN(32)) ifc();

  rv_exec_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(ifc),
    .pc(pc), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] fq[$];
  logic [72:0] dq[$];
  logic [31:0] exp_pc  = 32'h0;
  logic [31:0] exp_ret = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: fetch addresses on each new request, dispatch fields on acceptance.
  initial begin
    logic        prev_mv;
    logic [31:0] fa;
    logic [72:0] rec;
    prev_mv = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.mem_rd_addr_valid === 1'b1 && !prev_mv) begin
        if (fq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fetch: got addr 0x%0h, want no fetch", ifc.mem_rd_addr);
        end else begin
          fa = fq.pop_front();
          check("fetch_addr", ifc.mem_rd_addr, fa);
        end
      end
      prev_mv = (ifc.mem_rd_addr_valid === 1'b1);
      if (ifc.alu_inputs_valid === 1'b1 && ifc.alu_ready === 1'b1) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_dispatch: got op %0d, want no dispatch", ifc.alu_op_code);
        end else begin
          rec = dq.pop_front();
          check("disp_op", ifc.alu_op_code, rec[72:69]);
          check("disp_A",  ifc.alu_input_A, rec[68:37]);
          check("disp_B",  ifc.alu_input_B, rec[36:5]);
          check("disp_rd", ifc.alu_reg_addr, rec[4:0]);
        end
      end
    end
  end

  task automatic clear_inputs();
    ifc.mem_rd_data = 32'h0; ifc.mem_rd_ack = 1'b0;
    ifc.reg_rd_data_a = 32'h0; ifc.reg_rd_data_b = 32'h0;
    ifc.reg_rd_a_ack = 1'b0; ifc.reg_rd_b_ack = 1'b0;
    ifc.alu_ready = 1'b0; ifc.alu_pc_branch_data = 32'h0;
    ifc.alu_pc_branch_data_valid = 1'b0; ifc.done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valids", {ifc.mem_rd_addr_valid, ifc.reg_rd_a_valid, ifc.reg_rd_b_valid,
                         ifc.alu_inputs_valid, illegal_instr}, 5'b0);
    check("rst_retired", instr_retired, 32'h0);
    check("rst_operands", {ifc.alu_op_code, ifc.alu_input_A, ifc.alu_input_B}, 68'h0);
    check("rst_addrs", {ifc.mem_rd_addr, ifc.reg_rd_addr_a, ifc.reg_rd_addr_b, ifc.alu_reg_addr}, 47'h0);
    reset = 1'b0;
    exp_pc = 32'h0;
    exp_ret = 32'h0;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.mem_rd_addr_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL fetch_timeout: got no request in 20 cycles, want a fetch");
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input logic [31:0] va, input logic [31:0] vb,
                           input logic [3:0] e_op, input logic [31:0] e_b, input logic [4:0] e_rd,
                           input logic e_need_b, input int mem_dly, input int a_dly, input int b_dly,
                           input int rdy_dly, input int done_dly, input logic br_v,
                           input logic [31:0] br_d, input logic spur);
    bit ok;
    int c0, c1, last;
    fq.push_back(exp_pc);
    dq.push_back({e_op, va, e_b, e_rd});
    wait_fetch(ok);
    if (!ok) return;
    c0 = cyc;
    for (int i = 0; i < mem_dly; i++) begin
      check("fetch_held", ifc.mem_rd_addr_valid, 1'b1);
      if (spur) begin
        ifc.done = 1'b1; ifc.alu_ready = 1'b1;
        ifc.reg_rd_a_ack = 1'b1; ifc.reg_rd_b_ack = 1'b1;
        ifc.reg_rd_data_a = 32'hBAD0BAD0; ifc.reg_rd_data_b = 32'hBAD0BAD0;
      end
      tick();
    end
    clear_inputs();
    ifc.mem_rd_data = instr; ifc.mem_rd_ack = 1'b1;
    tick();
    ifc.mem_rd_ack = 1'b0; ifc.mem_rd_data = 32'hDEADBEEF;
    check("fetch_drop", ifc.mem_rd_addr_valid, 1'b0);
    tick();
    check("rs1_addr", ifc.reg_rd_addr_a, instr[19:15]);
    if (e_need_b) check("rs2_addr", ifc.reg_rd_addr_b, instr[24:20]);
    last = (e_need_b && b_dly > a_dly) ? b_dly : a_dly;
    for (int c = 0; c <= last; c++) begin
      check("rd_a_valid", ifc.reg_rd_a_valid, c <= a_dly);
      check("rd_b_valid", ifc.reg_rd_b_valid, e_need_b && c <= b_dly);
      check("early_dispatch", ifc.alu_inputs_valid, 1'b0);
      ifc.reg_rd_a_ack = (c == a_dly);
      ifc.reg_rd_data_a = (c == a_dly) ? va : 32'h0BAD0BAD;
      ifc.reg_rd_b_ack = e_need_b && (c == b_dly);
      ifc.reg_rd_data_b = (c == b_dly) ? vb : 32'h0BAD0BAD;
      tick();
    end
    ifc.reg_rd_a_ack = 1'b0; ifc.reg_rd_b_ack = 1'b0;
    ifc.reg_rd_data_a = 32'h0; ifc.reg_rd_data_b = 32'h0;
    for (int r = 0; r <= rdy_dly; r++) begin
      check("disp_valid", ifc.alu_inputs_valid, 1'b1);
      check("hold_A", ifc.alu_input_A, va);
      check("hold_B", ifc.alu_input_B, e_b);
      check("hold_op_rd", {ifc.alu_op_code, ifc.alu_reg_addr}, {e_op, e_rd});
      ifc.alu_ready = (r == rdy_dly);
      tick();
    end
    ifc.alu_ready = 1'b0;
    check("disp_drop", ifc.alu_inputs_valid, 1'b0);
    c1 = cyc;
    for (int d = 0; d <= done_dly; d++) begin
      ifc.done = (d == done_dly);
      ifc.alu_pc_branch_data_valid = br_v && (d == done_dly);
      ifc.alu_pc_branch_data = br_d;
      if (d == done_dly) c1 = cyc;
      tick();
    end
    ifc.done = 1'b0; ifc.alu_pc_branch_data_valid = 1'b0;
    exp_pc = br_v ? br_d : exp_pc + 32'd4;
    exp_ret = exp_ret + 32'd1;
    check("pc", pc, exp_pc);
    check("retired", instr_retired, exp_ret);
    check("latency", c1 - c0, 4 + mem_dly + last + rdy_dly + done_dly);
  endtask

  task automatic run_illegal(input logic [31:0] instr);
    bit ok;
    fq.push_back(exp_pc);
    wait_fetch(ok);
    if (!ok) return;
    ifc.mem_rd_data = instr; ifc.mem_rd_ack = 1'b1;
    tick();
    ifc.mem_rd_ack = 1'b0;
    check("illegal_before", illegal_instr, 1'b0);
    tick();
    check("illegal_set", illegal_instr, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ifc.mem_rd_ack = 1'b1; ifc.done = 1'b1; ifc.alu_ready = 1'b1;
      ifc.reg_rd_a_ack = 1'b1; ifc.reg_rd_b_ack = 1'b1;
      tick();
      check("halt_quiet", {ifc.mem_rd_addr_valid, ifc.reg_rd_a_valid, ifc.reg_rd_b_valid,
                           ifc.alu_inputs_valid, illegal_instr}, 5'b00001);
    end
    clear_inputs();
    check("halt_pc", pc, exp_pc);
    check("halt_retired", instr_retired, exp_ret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [31:0] ill [3];
    clear_inputs();
    do_reset();
    // instr, A, B-in, op, B-exp, rd, need_b, mem, a, b, rdy, done, br_v, br_d, spurious
    run_instr(32'h002081B3, 32'd5,         32'd7,         4'd0, 32'd7,         5'd3,  1'b1, 0, 0, 0, 0, 0, 1'b0, 32'h0,        1'b0);
    run_instr(32'hFFF00293, 32'd0,         32'h12345678,  4'd0, 32'hFFFFFFFF,  5'd5,  1'b0, 0, 0, 0, 0, 0, 1'b0, 32'h0,        1'b0);
    run_instr(32'h40208333, 32'h10,        32'd3,         4'd1, 32'd3,         5'd6,  1'b1, 0, 1, 4, 0, 0, 1'b0, 32'h0,        1'b0);
    run_instr(32'h0020C3B3, 32'hA5A5A5A5,  32'h0F0F0F0F,  4'd2, 32'h0F0F0F0F,  5'd7,  1'b1, 0, 0, 0, 3, 0, 1'b0, 32'h0,        1'b0);
    run_instr(32'h4040D413, 32'h80000000,  32'h0,         4'd7, 32'd4,         5'd8,  1'b0, 0, 0, 0, 0, 1, 1'b1, 32'h100,      1'b0);
    run_instr(32'h002094B3, 32'd1,         32'd31,        4'd5, 32'd31,        5'd9,  1'b1, 2, 2, 0, 0, 2, 1'b0, 32'h0,        1'b1);
    run_instr(32'h7F00F513, 32'hFFFF0000,  32'h0,         4'd4, 32'h7F0,       5'd10, 1'b0, 0, 0, 0, 1, 0, 1'b1, 32'hFFFFFFFC, 1'b0);
    run_instr(32'h0020E5B3, 32'd1,         32'd2,         4'd3, 32'd2,         5'd11, 1'b1, 0, 3, 3, 0, 0, 1'b0, 32'h0,        1'b0);
    run_instr(32'h0020D633, 32'h80,        32'd3,         4'd6, 32'd3,         5'd12, 1'b1, 0, 0, 0, 0, 0, 1'b0, 32'hDEAD0000, 1'b0);
    run_instr(32'h8000C713, 32'h0000FFFF,  32'h0,         4'd2, 32'hFFFFF800,  5'd14, 1'b0, 1, 0, 0, 0, 0, 1'b0, 32'h0,        1'b0);

    // Reset while a fetch is outstanding, with an ack landing on the reset edge.
    fq.push_back(exp_pc);
    wait_fetch(ok);
    tick();
    check("fetch_held_pre_rst", ifc.mem_rd_addr_valid, 1'b1);
    ifc.mem_rd_data = 32'h002081B3; ifc.mem_rd_ack = 1'b1; reset = 1'b1;
    tick();
    ifc.mem_rd_ack = 1'b0; reset = 1'b0;
    exp_pc = 32'h0; exp_ret = 32'h0;
    check("midrst_pc", pc, 32'h0);
    check("midrst_retired", instr_retired, 32'h0);
    check("midrst_fetch_drop", ifc.mem_rd_addr_valid, 1'b0);
    run_instr(32'h002081B3, 32'd9, 32'd1, 4'd0, 32'd1, 5'd3, 1'b1, 0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);

    ill[0] = 32'h0020A633;
    ill[1] = 32'h40409413;
    ill[2] = 32'h0000007F;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_illegal(ill[k]);
    end

    check("fetch_queue_empty", fq.size(), 0);
    check("disp_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
